// File: rtl/mem_loader.sv
// mem_loader: assembles a little-endian byte stream into WORDSIZE-byte words and writes them to consecutive RAM addresses.
// Define MEM_LOADER_CHECKSUM_EN to verify a trailing mod-256 checksum byte after the last word.
module mem_loader #(
   parameter int WORDSIZE = 4,
   parameter int MEMSIZE  = 32 * 1024,
   parameter logic [$clog2(MEMSIZE)-1:0] BASE = '0
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [$clog2(MEMSIZE):0]   length,
   input  logic [7:0]                 byte_i,
   input  logic                       byte_valid,
   output logic                       byte_ready,
   output logic                       mem_write_en,
   output logic [$clog2(MEMSIZE)-1:0] mem_address,
   output logic [WORDSIZE*8-1:0]      mem_data_o,
   output logic                       busy,
   output logic                       done,
   output logic                       error
);
   localparam int AW = $clog2(MEMSIZE);
   localparam int CW = (WORDSIZE > 1) ? $clog2(WORDSIZE) : 1;
   localparam logic [CW-1:0] LAST_LANE = CW'(WORDSIZE - 1);

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE,
`ifdef MEM_LOADER_CHECKSUM_EN
      CHECK,
`endif
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [AW:0]           len_q, len_d;
   logic [AW:0]           word_cnt_q, word_cnt_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
   logic [WORDSIZE*8-1:0] asm_q, asm_d;
   logic [WORDSIZE*8-1:0] data_q, data_d;
   logic                  take;
`ifdef MEM_LOADER_CHECKSUM_EN
   logic [7:0]            sum_q, sum_d;
   logic                  error_q, error_d;
`endif

   assign take = byte_valid && byte_ready;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      addr_d     = addr_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      data_d     = data_q;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum_d      = sum_q;
      error_d    = error_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
`ifdef MEM_LOADER_CHECKSUM_EN
               sum_d   = 8'h00;
               error_d = 1'b0;
`endif
               if (length != '0) begin
                  len_d      = length;
                  addr_d     = BASE;
                  byte_cnt_d = '0;
                  word_cnt_d = '0;
                  state_d    = COLLECT;
               end else begin
                  state_d = DONE;
               end
            end
         end
         COLLECT: begin
            if (take) begin
               asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_i;
`ifdef MEM_LOADER_CHECKSUM_EN
               sum_d = sum_q + byte_i;
`endif
               // The output register only changes on entry to WRITE, so it holds between words.
               if (byte_cnt_q == LAST_LANE) begin
                  data_d  = asm_d;
                  state_d = WRITE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end
         end
         WRITE: begin
            if (word_cnt_q == len_q - 1'b1) begin
`ifdef MEM_LOADER_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = DONE;
`endif
            end else begin
               addr_d     = addr_q + 1'b1;
               word_cnt_d = word_cnt_q + 1'b1;
               byte_cnt_d = '0;
               state_d    = COLLECT;
            end
         end
`ifdef MEM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (take) begin
               error_d = (8'(sum_q + byte_i) != 8'h00);
               state_d = DONE;
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         word_cnt_q <= '0;
         addr_q     <= BASE;
         byte_cnt_q <= '0;
         asm_q      <= '0;
         data_q     <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
         sum_q      <= 8'h00;
         error_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         addr_q     <= addr_d;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         data_q     <= data_d;
`ifdef MEM_LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
         error_q    <= error_d;
`endif
      end
   end

   // Every output is a register or a decode of the state register.
`ifdef MEM_LOADER_CHECKSUM_EN
   assign byte_ready = (state_q == COLLECT) || (state_q == CHECK);
   assign error      = error_q;
`else
   assign byte_ready = (state_q == COLLECT);
   assign error      = 1'b0;
`endif
   assign mem_write_en = (state_q == WRITE);
   assign mem_address  = addr_q;
   assign mem_data_o   = data_q;
   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);

endmodule
